round_robin_arbiter32: RTL

ROUND_ROBIN_ARBITER32 -- requirements
Module: round_robin_arbiter32

---
 rtl/arb_defs.sv | 16 +
 rtl/round_robin_arbiter32_grant_decoder.sv | 10 +
 rtl/round_robin_arbiter32.sv | 64 ++++++
 3 files changed

// File: rtl/arb_defs.sv
// arb_defs: shared constants, state encoding and rotating priority search for the round-robin arbiter
package arb_defs;
  localparam int N_REQ = 32;
  localparam int IDX_W = 5;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] k;
    win = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) win = k;
    end
    return win;
  endfunction
endpackage

// File: rtl/round_robin_arbiter32_grant_decoder.sv
// grant_decoder: 5-to-32 one-hot decode of idx, all zero when en is low (ports: idx, en -> onehot)
module grant_decoder
  import arb_defs::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);
  assign onehot = en ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/round_robin_arbiter32.sv
// round_robin_arbiter32: 32-way round-robin arbiter with hold limit (ports: clk, rst, enable, req, done -> grant_valid, grant_idx, grant_onehot, timeout)
module round_robin_arbiter32
  import arb_defs::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);
  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n;
  logic [7:0]       cnt, cnt_n;
  logic             timeout_n;
  logic             last;
  assign last = cnt == 8'(MAX_HOLD - 1);
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    idx_n     = grant_idx;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (enable && |req) begin
        state_n = GRANT;
        idx_n   = rr_pick(req, ptr);
        cnt_n   = '0;
      end
    end else if (done || !req[grant_idx] || last) begin
      state_n   = IDLE;
      ptr_n     = grant_idx + 1'b1;
      timeout_n = !done && req[grant_idx];
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      grant_idx <= idx_n;
      timeout   <= timeout_n;
    end
  end
  assign grant_valid = state == GRANT;
  grant_decoder u_dec (
    .idx   (grant_idx),
    .en    (grant_valid),
    .onehot(grant_onehot)
  );
endmodule
